logic_reduce_n: RTL

- Parametrised, clocked successor to the team's 2-input AND cell.
- Folds a stream of WIDTH-bit operands into one result using a selectable bitwise op: AND, OR, XOR or NAND.
- Operands enter through a valid/ready handshake; the result leaves through one.
- Sits beside the 8-bit datapath ALU for multi-operand masking/parity jobs issued by the controller.

---
 rtl/logic_pkg.sv | 22 ++
 rtl/bitwise_op.sv | 25 ++
 rtl/logic_reduce_n.sv | 118 +++++++++++
 3 files changed

// File: rtl/logic_pkg.sv
// Shared encodings and helpers for the bitwise reduction engine and the ALU op select.
package logic_pkg;

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_NAND = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Identity fill bit for a mode; callers replicate it to their own width.
  function automatic logic identity(input mode_e m);
    return (m == MODE_AND) || (m == MODE_NAND);
  endfunction

endpackage

// File: rtl/bitwise_op.sv
// Combinational WIDTH-bit bitwise operator selected by mode.
module bitwise_op
  import logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mode_e             mode,
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  output logic [WIDTH-1:0]  z
);

  // Operator select
  always_comb begin
    z = '0;
    case (mode)
      MODE_AND:  z = x & y;
      MODE_OR:   z = x | y;
      MODE_XOR:  z = x ^ y;
      MODE_NAND: z = ~(x & y);
      default:   z = '0;
    endcase
  end

endmodule

// File: rtl/logic_reduce_n.sv
// Folds a handshaked stream of WIDTH-bit operands into one result with AND/OR/XOR/NAND.
module logic_reduce_n
  import logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MAX_OPS = 16,
  localparam int CNTW = $clog2(MAX_OPS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [CNTW-1:0]   len,
  input  logic [WIDTH-1:0]  a,
  input  logic              a_valid,
  output logic              a_ready,
  output logic [WIDTH-1:0]  y,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              busy
);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   y_q, y_d;

  mode_e              mode_in;
  mode_e              op_mode;
  logic [CNTW-1:0]    len_eff;
  logic [WIDTH-1:0]   ident_in;
  logic [WIDTH-1:0]   acc_op;

  assign mode_in  = mode_e'(mode);
  assign len_eff  = (len > CNTW'(MAX_OPS)) ? CNTW'(MAX_OPS) : len;
  assign ident_in = {WIDTH{identity(mode_in)}};
  // NAND folds as AND; the inversion happens once when the result is loaded.
  assign op_mode  = (mode_q == MODE_NAND) ? MODE_AND : mode_q;

  bitwise_op #(.WIDTH(WIDTH)) u_op (
    .mode (op_mode),
    .x    (acc_q),
    .y    (a),
    .z    (acc_op)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = mode_in;
          cnt_d  = len_eff;
          acc_d  = ident_in;
          if (len_eff != CNTW'(0)) begin
            state_d = ACCUM;
          end else begin
            state_d = DONE;
            y_d     = (mode_in == MODE_NAND) ? ~ident_in : ident_in;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (a_valid) begin
          acc_d = acc_op;
          cnt_d = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
            state_d = DONE;
            y_d     = (mode_q == MODE_NAND) ? ~acc_op : acc_op;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      DONE: begin
        if (y_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_AND;
      cnt_q   <= '0;
      acc_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
    end
  end

  assign a_ready = (state_q == ACCUM);
  assign y_valid = (state_q == DONE);
  assign busy    = (state_q != IDLE);
  assign y       = y_q;

endmodule
